// File: rtl/umi_reghost.sv
// rtl/umi_reghost.sv - single-outstanding register access to UMI request/response bridge
// Optional: define UMI_REGHOST_POSTED_EN to issue writes as posted requests.
module umi_reghost #(
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int DW      = 256,
    parameter int RW      = 32,
    parameter int TOW     = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] host_srcaddr,
    input  logic          reg_read,
    input  logic          reg_write,
    input  logic [AW-1:0] reg_addr,
    input  logic [RW-1:0] reg_wrdata,
    output logic          reg_busy,
    output logic          reg_done,
    output logic          reg_error,
    output logic [RW-1:0] reg_rddata,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;
`ifdef UMI_REGHOST_POSTED_EN
    localparam logic [4:0] WRITE_OP   = 5'h05;
`else
    localparam logic [4:0] WRITE_OP   = 5'h03;
`endif
    localparam logic [2:0]     SIZE    = 3'($clog2(RW/8));
    localparam logic [TOW-1:0] TO_LAST = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_n;

    logic           is_write;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  src_q;
    logic [RW-1:0]  wrdata_q;
    logic [TOW-1:0] cnt;
    logic           done_q;
    logic           err_q;
    logic [RW-1:0]  rddata_q;
    logic           rready_q;

    logic capture, finish, fin_err, load_rd, req_hs, resp_hs, bad_resp;

    assign req_hs   = (state == REQ) && uhost_req_ready;
    assign resp_hs  = uhost_resp_valid && uhost_resp_ready;
    assign bad_resp = (uhost_resp_cmd[4:0] != (is_write ? RESP_WRITE : RESP_READ))
                   || (uhost_resp_dstaddr != src_q);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        finish  = 1'b0;
        fin_err = 1'b0;
        load_rd = 1'b0;
        case (state)
            IDLE: begin
                if (reg_write || reg_read) begin
                    capture = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_n = RESP;
`ifdef UMI_REGHOST_POSTED_EN
                    if (is_write) state_n = IDLE;
`endif
                end
            end
            RESP: begin
                // A response arriving on the last timeout cycle still wins.
                if (resp_hs) begin
                    state_n = IDLE;
                    finish  = 1'b1;
                    fin_err = bad_resp;
                    load_rd = !bad_resp && !is_write;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_n = IDLE;
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            is_write <= 1'b0;
            addr_q   <= '0;
            src_q    <= '0;
            wrdata_q <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rddata_q <= '0;
            rready_q <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            done_q   <= finish;
            err_q    <= finish && fin_err;
            if (capture) begin
                is_write <= reg_write;
                addr_q   <= reg_addr;
                src_q    <= host_srcaddr;
                wrdata_q <= reg_wrdata;
            end
            if (state != RESP)  cnt <= '0;
            else if (cnt != '1) cnt <= cnt + 1'b1;
            if (load_rd) rddata_q <= uhost_resp_data[RW-1:0];
        end
    end

    always_comb begin
        uhost_req_cmd      = '0;
        uhost_req_cmd[4:0] = is_write ? WRITE_OP : REQ_READ;
        uhost_req_cmd[7:5] = SIZE;
        uhost_req_cmd[22]  = 1'b1;
    end

    assign uhost_req_valid   = (state == REQ);
    assign uhost_req_dstaddr = addr_q;
    assign uhost_req_srcaddr = src_q;
    assign uhost_req_data    = DW'(wrdata_q);
    assign uhost_resp_ready  = rready_q;
    assign reg_busy          = (state != IDLE);
    assign reg_rddata        = rddata_q;
    assign reg_error         = err_q;
`ifdef UMI_REGHOST_POSTED_EN
    assign reg_done          = done_q || (req_hs && is_write);
`else
    assign reg_done          = done_q;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{uhost_resp_srcaddr, uhost_resp_cmd, uhost_resp_data};

endmodule

// File: tb/tb_umi_reghost.sv
// tb/tb_umi_reghost.sv - randomized self-checking bench for umi_reghost
module tb_umi_reghost;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          nreset;
    logic [63:0]   host_srcaddr;
    logic          reg_read, reg_write;
    logic [63:0]   reg_addr;
    logic [31:0]   reg_wrdata;
    logic          reg_busy, reg_done, reg_error;
    logic [31:0]   reg_rddata;
    logic          uhost_req_valid;
    logic [31:0]   uhost_req_cmd;
    logic [63:0]   uhost_req_dstaddr, uhost_req_srcaddr;
    logic [255:0]  uhost_req_data;
    logic          uhost_req_ready;
    logic          uhost_resp_valid;
    logic [31:0]   uhost_resp_cmd;
    logic [63:0]   uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [255:0]  uhost_resp_data;
    logic          uhost_resp_ready;

    umi_reghost #(.TIMEOUT(TO)) dut (
        .clk(clk), .nreset(nreset), .host_srcaddr(host_srcaddr),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_wrdata(reg_wrdata), .reg_busy(reg_busy), .reg_done(reg_done),
        .reg_error(reg_error), .reg_rddata(reg_rddata),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected cycle-by-cycle view, written by the driver, read by the compare process.
    bit           chk_en = 0;
    bit           e_busy, e_valid, e_done, e_err;
    logic [31:0]  e_rddata;
    logic [31:0]  e_cmd;
    logic [63:0]  e_dst, e_src;
    logic [255:0] e_data;

    logic [31:0]  last_cmd;
    logic [63:0]  last_dst;
    logic [255:0] last_data;
    int           done_cyc;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", reg_busy, e_busy);
            chk("req_valid", uhost_req_valid, e_valid);
            chk("done", reg_done, e_done);
            chk("rddata", reg_rddata, e_rddata);
            chk("resp_ready", uhost_resp_ready, 1'b1);
            if (e_done) chk("error", reg_error, e_err);
            if (e_valid) begin
                chk("req_cmd", uhost_req_cmd, e_cmd);
                chk("req_dst", uhost_req_dstaddr, e_dst);
                chk("req_src", uhost_req_srcaddr, e_src);
                chk("req_data", uhost_req_data, e_data);
            end
        end
        if (uhost_req_valid) begin
            last_cmd  = uhost_req_cmd;
            last_dst  = uhost_req_dstaddr;
            last_data = uhost_req_data;
        end
        if (reg_done) done_cyc = cyc;
    end

    function automatic logic [31:0] exp_cmd(input int op);
        return 32'(op) | (32'($clog2(32/8)) << 5) | (32'd1 << 22);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    int t_strobe;

    // mode: 0 good response, 1 wrong opcode, 2 wrong dstaddr; dly >= TO means no response.
    task automatic do_txn(input bit wr, input logic [63:0] addr, input logic [31:0] wd,
                          input int bp, input int dly, input int mode, input logic [31:0] rdat);
        logic [63:0] src;
        bit          timed_out;
        logic [4:0]  op;
        src = {$urandom, $urandom};
        @(posedge clk); #1;
        t_strobe     = cyc;
        reg_write    = wr;
        reg_read     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        reg_addr     = addr;
        reg_wrdata   = wd;
        host_srcaddr = src;
        uhost_req_ready = 1'($urandom_range(0, 1));
        e_busy = 0; e_valid = 0; e_done = 0;
        e_cmd  = exp_cmd(wr ? 3 : 1);
        e_dst  = addr;
        e_src  = src;
        e_data = {224'd0, wd};
        for (int i = 0; i <= bp; i++) begin
            @(posedge clk); #1;
            reg_write    = 1'($urandom);
            reg_read     = 1'($urandom);
            reg_addr     = {$urandom, $urandom};
            reg_wrdata   = $urandom;
            host_srcaddr = {$urandom, $urandom};
            uhost_req_ready = (i == bp);
            e_busy = 1; e_valid = 1;
        end
        timed_out = 0;
        for (int i = 0; i < TO; i++) begin
            @(posedge clk); #1;
            uhost_req_ready = 1'($urandom);
            e_valid = 0;
            if (i == dly) begin
                op = wr ? 5'h04 : 5'h02;
                if (mode == 1) op = wr ? 5'h02 : 5'h04;
                uhost_resp_valid   = 1;
                uhost_resp_cmd     = ($urandom & ~32'h1f) | 32'(op);
                uhost_resp_dstaddr = (mode == 2) ? (src ^ (64'd1 << $urandom_range(0, 63))) : src;
                uhost_resp_srcaddr = {$urandom, $urandom};
                uhost_resp_data    = rnd256();
                uhost_resp_data[31:0] = rdat;
                break;
            end
            uhost_resp_valid = 0;
            if (i == TO - 1) timed_out = 1;
        end
        @(posedge clk); #1;
        uhost_resp_valid = 0;
        reg_write = 0; reg_read = 0;
        e_busy = 0; e_done = 1;
        e_err  = timed_out || (mode != 0);
        if (!e_err && !wr) e_rddata = rdat;
        @(posedge clk); #1;
        e_done = 0;
        if (timed_out) begin
            uhost_resp_valid   = 1;
            uhost_resp_cmd     = wr ? 32'h4 : 32'h2;
            uhost_resp_dstaddr = src;
            uhost_resp_data    = rnd256();
            @(posedge clk); #1;
            uhost_resp_valid = 0;
        end
    endtask

    initial begin
        nreset = 0;
        host_srcaddr = 0; reg_read = 0; reg_write = 0; reg_addr = 0; reg_wrdata = 0;
        uhost_req_ready = 0; uhost_resp_valid = 0; uhost_resp_cmd = 0;
        uhost_resp_dstaddr = 0; uhost_resp_srcaddr = 0; uhost_resp_data = 0;
        e_rddata = 0; e_busy = 0; e_valid = 0; e_done = 0; e_err = 0;
        e_cmd = 0; e_dst = 0; e_src = 0; e_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", reg_busy, 1'b0);
        chk("rst_done", reg_done, 1'b0);
        chk("rst_error", reg_error, 1'b0);
        chk("rst_rddata", reg_rddata, 32'h0);
        chk("rst_req_valid", uhost_req_valid, 1'b0);
        chk("rst_resp_ready", uhost_resp_ready, 1'b0);
        @(posedge clk); #1;
        nreset = 1;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;

        // Directed write then read-back of the same register.
        do_txn(1, 64'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        chk("wr_cmd_literal", last_cmd, 32'h0040_0043);
        chk("wr_dst_literal", last_dst, 64'h100);
        chk("wr_data_literal", last_data[31:0], 32'hDEADBEEF);
        chk("wr_latency", done_cyc - t_strobe, 3);
        do_txn(0, 64'h100, 32'h0, 0, 0, 0, 32'hDEADBEEF);
        chk("rd_cmd_literal", last_cmd, 32'h0040_0041);
        chk("rd_data_literal", reg_rddata, 32'hDEADBEEF);
        chk("rd_latency", done_cyc - t_strobe, 3);

        // Backpressure, bad responses, timeout boundaries.
        do_txn(0, 64'h200, 32'h0, 5, 1, 0, 32'h1234_5678);
        do_txn(0, 64'h300, 32'h0, 0, 0, 1, 32'hAAAA_AAAA);
        chk("badop_rddata_kept", reg_rddata, 32'h1234_5678);
        do_txn(0, 64'h300, 32'h0, 1, 2, 2, 32'hBBBB_BBBB);
        chk("baddst_rddata_kept", reg_rddata, 32'h1234_5678);
        do_txn(0, 64'h400, 32'h0, 0, TO - 1, 0, 32'hCAFE_F00D);
        chk("late_edge_resp_wins", reg_rddata, 32'hCAFE_F00D);
        do_txn(1, 64'h500, 32'h5555_0000, 0, 100, 0, 32'h0);
        chk("timeout_latency", done_cyc - t_strobe, 22);

        for (int n = 0; n < 60; n++) begin
            int r, d, m;
            r = $urandom_range(0, 9);
            d = (r < 7) ? (r % 4) : (r == 7) ? TO - 1 : (r == 8) ? TO : 30;
            m = $urandom_range(0, 5);
            m = (m < 4) ? 0 : m - 3;
            do_txn(1'($urandom), {$urandom, $urandom}, $urandom, $urandom_range(0, 3),
                   d, m, $urandom);
        end

        // Reset during an outstanding request aborts it.
        chk_en = 0;
        @(posedge clk); #1;
        reg_read = 1; reg_addr = 64'h600; host_srcaddr = 64'h77;
        uhost_req_ready = 0;
        @(posedge clk); #1;
        reg_read = 0;
        #2;
        chk("abort_pre_valid", uhost_req_valid, 1'b1);
        nreset = 0;
        #1;
        chk("abort_valid_drop", uhost_req_valid, 1'b0);
        chk("abort_busy", reg_busy, 1'b0);
        chk("abort_resp_ready", uhost_resp_ready, 1'b0);
        chk("abort_rddata", reg_rddata, 32'h0);
        @(posedge clk); #1;
        nreset = 1;
        e_rddata = 0; e_busy = 0; e_valid = 0; e_done = 0;
        @(posedge clk); #1;
        chk_en = 1;
        repeat (5) @(posedge clk);
        do_txn(0, 64'h700, 32'h0, 0, 0, 0, 32'h0BAD_CAFE);
        @(negedge clk);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/umi_reghost.md
Name: umi_reghost

Overview:
- Host-side initiator that converts a simple single-beat register access interface (read/write strobes, address, write data) into UMI requests.
- Returns the read data or the write completion from the matching UMI response.
- Mirror of the device-side register interface. Sits between a local controller (CPU bridge, config sequencer, test agent) and a UMI request/response channel pair.
- One transaction outstanding at a time; response timeout detection built in.

Parameters:
- CW, 32, UMI command width
- AW, 64, UMI/register address width
- DW, 256, UMI data width
- RW, 32, register data width (power of 2, 8..DW)
- TOW, 16, response timeout counter width
- TIMEOUT, 1000, cycles to wait for a response before error (0 = disabled)

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- host_srcaddr  input  AW  return address placed in request srcaddr
- reg_read  input  1  read strobe, sampled only when reg_busy=0
- reg_write  input  1  write strobe, sampled only when reg_busy=0
- reg_addr  input  AW  register address
- reg_wrdata  input  RW  write data
- reg_busy  output  1  transaction in progress
- reg_done  output  1  one-cycle completion pulse
- reg_error  output  1  valid with reg_done; bad opcode, bad address, or timeout
- reg_rddata  output  RW  read data, held until next reg_done
- uhost_req_valid  output  1  UMI request valid
- uhost_req_cmd  output  CW  UMI request command
- uhost_req_dstaddr  output  AW  request destination address (=reg_addr)
- uhost_req_srcaddr  output  AW  request source address (=host_srcaddr)
- uhost_req_data  output  DW  request data, reg_wrdata zero-extended
- uhost_req_ready  input  1  UMI request ready
- uhost_resp_valid  input  1  UMI response valid
- uhost_resp_cmd  input  CW  response command
- uhost_resp_dstaddr  input  AW  response destination address
- uhost_resp_srcaddr  input  AW  response source address (unused)
- uhost_resp_data  input  DW  response data
- uhost_resp_ready  output  1  UMI response ready

Behaviour:
- Clock and reset: one clock, clk. Reset nreset is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; uhost_resp_ready=0 only while nreset=0.
- States:
  - IDLE: if reg_write, capture write. Else if reg_read, capture read. Write wins if both are set. Capture addr, wrdata and host_srcaddr into registers. Go to REQ next cycle; reg_busy=1 from the following cycle.
  - REQ: uhost_req_valid=1 with stable fields until uhost_req_valid & uhost_req_ready. Then go to RESP.
  - RESP: uhost_resp_ready=1; timeout counter runs. On a response handshake go to IDLE and pulse reg_done.
- Latency: with ready=1 and an immediate response, reg_done occurs 3 cycles after the strobe.
- Command encoding:
  - cmd[4:0] opcode: REQ_READ=0x01, REQ_WRITE=0x03.
  - cmd[7:5] size = clog2(RW/8) (2 for RW=32).
  - cmd[15:8] len = 0.
  - cmd[22] eom = 1; all other bits 0.
- Response check:
  - Expected opcode: RESP_READ=0x02 for a read, RESP_WRITE=0x04 for a write.
  - uhost_resp_dstaddr must equal the captured srcaddr.
  - Mismatch sets reg_error=1 with reg_done; the response is still consumed.
  - On a good read, reg_rddata = uhost_resp_data[RW-1:0]. On a write or any error, reg_rddata is unchanged.
- Timeout:
  - Counter clears on entering RESP and saturates at 2^TOW-1.
  - When count reaches TIMEOUT-1 with no response: reg_done=1, reg_error=1, return to IDLE.
  - A same-cycle response beats the timeout.
- IDLE drain: uhost_resp_ready=1 in IDLE so stray or late responses are consumed and discarded, with no reg_done.
- Strobes while busy are ignored and not queued.
- Reset mid-transaction aborts it: uhost_req_valid drops asynchronously and no reg_done is issued.

Optional Feature:
- Macro: UMI_REGHOST_POSTED_EN
- Defined:
  - Writes use REQ_POSTED opcode 0x05.
  - On the request handshake, pulse reg_done (reg_error=0) and go straight to IDLE, skipping RESP.
  - Reads are unchanged.
- Undefined: writes are acknowledged (REQ_WRITE) as above; opcode 0x05 is never generated.

Test Plan:
- Write: reg_write, addr=0x100, data=0xDEADBEEF, req_ready=1 -> request cmd[4:0]=0x03, size=2, dstaddr=0x100, data[31:0]=0xDEADBEEF. RESP_WRITE returned to host_srcaddr -> reg_done=1, reg_error=0.
- Read back: reg_read addr=0x100 -> cmd opcode 0x01; response RESP_READ with data 0xDEADBEEF -> reg_rddata=0xDEADBEEF, reg_done one cycle wide.
- Backpressure: req_ready=0 for 5 cycles -> valid and all fields held stable for 5 cycles; a second reg_read during that time is ignored.
- Bad response: reply with opcode 0x04 to a read, or dstaddr mismatch -> reg_done=1, reg_error=1, reg_rddata unchanged.
- Timeout: TIMEOUT=20, no response -> reg_done and reg_error exactly 20 cycles after entering RESP. A late response in IDLE is consumed with no reg_done.
- Posted (UMI_REGHOST_POSTED_EN): reg_write -> opcode 0x05, reg_done on the request-handshake cycle, uhost_resp_ready never raised in RESP.
